// File: rtl/rotated_sprite_writer.sv
// Tags rotated CORDIC outputs with their matched valid/last, converts to pixel coordinates and sets bits in a sprite bitmap.
// Tap result applied LATENCY cycles after acceptance; in_ready only in RUN, no stall of the upstream rotator.
module rotated_sprite_writer #(
  parameter int LATENCY = 19,
  parameter int CW      = 16,
  parameter int FRAC    = 8,
  parameter int IMG_W   = 48,
  parameter int IMG_H   = 48,
  parameter int CENTER  = 24
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             frame_start,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic [CW-1:0]    xo,
  input  logic [CW-1:0]    yo,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       drop_count,
  input  logic [5:0]       rd_row,
  output logic [IMG_W-1:0] rd_data
);

  localparam int AW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int ROUND = 1 << (FRAC - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

  state_t             state;
  logic [RW-1:0]      clr_row;
  logic [LATENCY-1:0] vld_sr;
  logic [LATENCY-1:0] last_sr;
  logic [IMG_W-1:0]   bitmap [IMG_H];

  logic               accept;
  logic               tap_vld;
  logic               tap_last;
  logic signed [CW+1:0] xi;
  logic signed [CW+1:0] yi;
  logic               x_ok;
  logic               y_ok;
  logic               wr_en;
  logic               drop_en;
  logic               clr_en;
  logic [RW-1:0]      wr_row;
  logic [IMG_W-1:0]   wr_mask;

  // Round half toward +inf, then move the origin to the sprite centre.
  function automatic logic signed [CW+1:0] to_pix(input logic [CW-1:0] v);
    logic signed [CW+1:0] t;
    t = $signed({{2{v[CW-1]}}, v}) + $signed((CW+2)'(ROUND));
    return (t >>> FRAC) + $signed((CW+2)'(CENTER));
  endfunction

  assign accept   = in_valid && in_ready;
  assign tap_vld  = vld_sr[LATENCY-1];
  assign tap_last = last_sr[LATENCY-1];

  assign xi      = to_pix(xo);
  assign yi      = to_pix(yo);
  assign x_ok    = !xi[CW+1] && (xi[CW:0] < (CW+1)'(IMG_W));
  assign y_ok    = !yi[CW+1] && (yi[CW:0] < (CW+1)'(IMG_H));
  assign wr_en   = tap_vld && x_ok && y_ok;
  assign drop_en = tap_vld && !(x_ok && y_ok);
  assign wr_row  = yi[RW-1:0];
  assign wr_mask = IMG_W'(1) << xi[AW-1:0];
  assign clr_en  = (state == CLEAR);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr  <= {vld_sr[LATENCY-2:0], accept};
      last_sr <= {last_sr[LATENCY-2:0], accept && in_last};
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= IDLE;
      clr_row    <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      drop_count <= '0;
    end else begin
      frame_done <= tap_vld && tap_last;
      if (drop_en && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
      case (state)
        IDLE: begin
          if (frame_start) begin
            state      <= CLEAR;
            busy       <= 1'b1;
            clr_row    <= '0;
            drop_count <= '0;
          end
        end
        CLEAR: begin
          clr_row <= clr_row + RW'(1);
          if (clr_row == RW'(IMG_H - 1)) begin
            state    <= RUN;
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          if (accept && in_last) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (tap_vld && tap_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  // Clearing and pixel writes never overlap; the clear still takes priority.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int r = 0; r < IMG_H; r++) begin
        bitmap[r] <= '0;
      end
    end else begin
      for (int r = 0; r < IMG_H; r++) begin
        if (clr_en && clr_row == RW'(r)) begin
          bitmap[r] <= '0;
        end else if (wr_en && wr_row == RW'(r)) begin
          bitmap[r] <= bitmap[r] | wr_mask;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      rd_data <= '0;
    end else if (int'(rd_row) < IMG_H) begin
      rd_data <= bitmap[rd_row];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_rotated_sprite_writer.sv
// Scoreboarded bench for rotated_sprite_writer: models pixel conversion, drops and frame completion timing.
module tb_rotated_sprite_writer;

  logic        clk;
  logic        areset_n;
  logic        frame_start;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] xo;
  logic [15:0] yo;
  logic        busy;
  logic        frame_done;
  logic [7:0]  drop_count;
  logic [5:0]  rd_row;
  logic [47:0] rd_data;

  rotated_sprite_writer dut (
    .clk        (clk),
    .areset_n   (areset_n),
    .frame_start(frame_start),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .xo         (xo),
    .yo         (yo),
    .busy       (busy),
    .frame_done (frame_done),
    .drop_count (drop_count),
    .rd_row     (rd_row),
    .rd_data    (rd_data)
  );

  typedef struct {
    int done_cyc;
    int drops;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] sched_x[int];
  logic [15:0] sched_y[int];
  logic [47:0] exp_bmp [48];
  int          exp_drop;
  int          cyc;
  int          n_checks;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Present scheduled CORDIC results on the edge their tap emerges; noise otherwise.
  always @(negedge clk) begin
    if (sched_x.exists(cyc + 1)) begin
      xo = sched_x[cyc + 1];
      yo = sched_y[cyc + 1];
    end else begin
      xo = 16'($urandom);
      yo = 16'($urandom);
    end
  end

  always @(negedge clk) begin
    if (areset_n && frame_done) begin
      if (sb.size() == 0) begin
        chk("spurious_frame_done", frame_done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("done_drop_count", drop_count, e.drops);
      end
    end
  end

  function automatic int tb_pix(input logic [15:0] v);
    int s;
    s = int'($signed(v)) + 128;
    if (s >= 0) return s / 256 + 24;
    return -((-s + 255) / 256) + 24;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 48; r++) exp_bmp[r] = '0;
    exp_drop = 0;
  endtask

  // Called at a negedge; drives the sample once in_ready is seen, returns one negedge later.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic last, output int key);
    int n;
    int px;
    int py;
    n = 0;
    key = -1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", in_ready, 1);
      return;
    end
    in_valid = 1'b1;
    in_last  = last;
    key = cyc + 20;
    sched_x[key] = x;
    sched_y[key] = y;
    px = tb_pix(x);
    py = tb_pix(y);
    if (px >= 0 && px < 48 && py >= 0 && py < 48) exp_bmp[py][px] = 1'b1;
    else if (exp_drop < 255) exp_drop++;
    if (last) sb.push_back('{key, exp_drop});
    @(negedge clk);
  endtask

  task automatic start_frame();
    int c;
    int n;
    @(negedge clk);
    frame_start = 1'b1;
    c = cyc;
    clear_model();
    @(negedge clk);
    frame_start = 1'b0;
    chk("busy_on_start", busy, 1);
    chk("drop_reset_on_start", drop_count, 0);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("clear_length", cyc - (c + 1), 48);
  endtask

  task automatic wait_idle();
    int n;
    logic [1:0] pend;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    pend = {busy, sb.size() != 0};
    if (n >= 2000) chk("idle_timeout", pend, 0);
    @(negedge clk);
  endtask

  task automatic check_rows(input string tag);
    for (int r = 0; r < 48; r++) begin
      rd_row = r[5:0];
      @(negedge clk);
      chk($sformatf("%s_row%0d", tag, r), rd_data, exp_bmp[r]);
    end
    rd_row = 6'd50;
    @(negedge clk);
    chk("rd_row_out_of_range", rd_data, 0);
  endtask

  initial begin
    int k;
    int k1;
    int xs;
    int ys;
    logic [47:0] row_exp;
    n_checks = 0;
    n_fail   = 0;
    areset_n = 1'b0;
    frame_start = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    rd_row   = 6'd0;
    clear_model();
    repeat (3) @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_rd_data", rd_data, 0);

    // Single sample: (5.0, -2.5) lands at row 22, col 29.
    start_frame();
    send(16'h0500, 16'hFD80, 1'b1, k);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("drain_in_ready", in_ready, 0);
    chk("drain_busy", busy, 1);
    wait_idle();
    rd_row = 6'd22;
    @(negedge clk);
    row_exp = 48'd1 << 29;
    chk("single_row22", rd_data, row_exp);
    check_rows("single");

    // Rounding boundaries on the left/right edges.
    start_frame();
    send(16'hE800, 16'h0000, 1'b0, k);
    send(16'hE780, 16'h0000, 1'b0, k);
    send(16'hE740, 16'h0000, 1'b0, k);
    send(16'h1800, 16'h0000, 1'b1, k);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_idle();
    chk("bound_drop_count", drop_count, 2);
    rd_row = 6'd24;
    @(negedge clk);
    chk("bound_row24", rd_data, 48'h1);
    check_rows("bound");

    // in_valid held through CLEAR and DRAIN, 36 back-to-back samples.
    in_valid = 1'b1;
    in_last  = 1'b1;
    start_frame();
    for (int i = 0; i < 36; i++) begin
      xs = int'($urandom_range(0, 11000)) - 5500;
      ys = int'($urandom_range(0, 11000)) - 5500;
      send(xs[15:0], ys[15:0], i == 35, k);
      in_last = 1'b1;
    end
    wait_idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("stream_drop_count", drop_count, exp_drop);
    check_rows("stream");

    // Saturation: a few real pixels, then 300 drops.
    start_frame();
    send(16'h0000, 16'h0000, 1'b0, k);
    send(16'h0300, 16'hF600, 1'b0, k);
    send(16'hF000, 16'h0A00, 1'b0, k);
    for (int i = 0; i < 300; i++) begin
      send(16'h7000, 16'(i * 7), i == 299, k);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_idle();
    chk("sat_drop_count", drop_count, 255);
    check_rows("sat");

    // New frame clears everything; then read-during-write on row 10.
    start_frame();
    check_rows("cleared");
    rd_row = 6'd10;
    send(16'hED00, 16'hF200, 1'b0, k1);
    send(16'h1000, 16'hF200, 1'b1, k);
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int n = 0; n < 100 && cyc < k1; n++) @(negedge clk);
    chk("rdw_old", rd_data, 0);
    @(negedge clk);
    row_exp = 48'd1 << 5;
    chk("rdw_first", rd_data, row_exp);
    @(negedge clk);
    row_exp = (48'd1 << 5) | (48'd1 << 40);
    chk("rdw_second", rd_data, row_exp);
    wait_idle();

    // Reset mid-RUN with samples in flight.
    start_frame();
    for (int i = 0; i < 5; i++) begin
      send(16'(i * 256), 16'(i * 256), 1'b0, k);
    end
    areset_n = 1'b0;
    #2;
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    areset_n = 1'b1;
    in_valid = 1'b0;
    clear_model();
    repeat (30) @(negedge clk);
    chk("midrst_busy_after", busy, 0);
    chk("midrst_drop_count", drop_count, 0);
    check_rows("midrst");
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
